// File: rtl/pipe_mux_nx1.sv
// N-to-1 multiplexer feeding a single registered output stage with valid/ready
// on both sides; the source channel is picked by index (directed) or round-robin.
module pipe_mux_nx1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 stall,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);

  localparam int NP = 1 << SEL_W;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [NP-1:0]    valid_ext;
  logic [SEL_W-1:0] cand_idx;
  logic             cand_vld;
  logic [WIDTH-1:0] cand_word;
  logic [SEL_W-1:0] ptr_nxt;
  logic             can_load;
  logic             grant;
  logic             drain;

  // Padding the valid vector to the full select range makes sel >= N
  // look like an idle channel, so it can never be granted.
  always_comb begin
    valid_ext = '0;
    valid_ext[N-1:0] = in_valid;
  end

  always_comb begin
    int idx;
    logic [SEL_W-1:0] idx_s;
    idx      = 0;
    idx_s    = '0;
    cand_idx = '0;
    cand_vld = 1'b0;
    if (!mode) begin
      cand_idx = sel;
      cand_vld = valid_ext[sel];
    end else begin
      // Scan from the farthest offset down so the nearest requester to ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        idx_s = SEL_W'(idx);
        if (valid_ext[idx_s]) begin
          cand_idx = idx_s;
          cand_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cand_word = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_idx == SEL_W'(i)) cand_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_nxt  = (cand_idx == SEL_W'(N - 1)) ? '0 : cand_idx + 1'b1;
  assign can_load = (!out_valid_q || out_ready) && !stall && !flush && !rst;
  assign grant    = can_load && cand_vld;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = grant && (cand_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (grant) begin
      out_data_d  = cand_word;
      out_ch_d    = cand_idx;
      out_valid_d = 1'b1;
      if (mode) ptr_d = ptr_nxt;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Bench for pipe_mux_nx1: directed scenarios plus a randomized run against a
// transaction-level reference model; a second 3-channel instance covers odd N.
module tb_pipe_mux_nx1;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [1:0]     sel;
  logic           mode, stall, flush, out_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     out_ch;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [1:0]     sel3;
  logic           mode3, stall3, flush3, out_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic [1:0]     out_ch3;

  int checks = 0;
  int failures = 0;

  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_ch;
  int          m_ptr;

  pipe_mux_nx1 #(.WIDTH(W), .N(N), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .stall(stall), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
  );

  pipe_mux_nx1 #(.WIDTH(W), .N(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .mode(mode3), .stall(stall3), .flush(flush3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ch(out_ch3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input int c);
    return W'(in_data >> (c * W));
  endfunction

  // Granted channel for the current inputs, or -1 for none.
  function automatic int exp_grant();
    if (rst || flush || stall || (m_valid && !out_ready)) return -1;
    if (!mode) begin
      if (int'(sel) < N && ((in_valid >> sel) & 4'd1) != 0) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (((in_valid >> c) & 4'd1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (flush) begin
      m_valid = 1'b0;
      m_data  = '0;
    end else if (g >= 0) begin
      m_data  = word_of(g);
      m_ch    = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    in_data = '0; in_valid = '0; sel = '0; mode = 1'b0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0;
    stall3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    in_valid = 4'hF; mode = 1'b1; out_ready = 1'b1;
    in_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    in_valid3 = 3'b111; mode3 = 1'b1; out_ready3 = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin failures++; $display("FAIL reset_dut3 got=%b/%b exp=0/000", out_valid3, in_ready3); end
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000;
    in_data = {32'hA5A50003, 32'h0, 32'h0, 32'h0};
    in_valid3 = '0;
    #1;
    checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL first_grant_ready got=%b exp=1000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A50003 || out_ch !== 2'd3) begin
      failures++; $display("FAIL first_grant_load got=%b/%h/%0d exp=1/a5a50003/3", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_directed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {$urandom, 32'hCAFE0002, $urandom, $urandom};
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL directed_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE0002 || out_ch !== 2'd2) begin
      failures++; $display("FAIL directed_load got=%b/%h/%0d exp=1/cafe0002/2", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    sel = 2'd0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL directed_idle_sel got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'hCAFE0002 || out_ch !== 2'd2) begin
      failures++; $display("FAIL directed_drain got=%b/%h/%0d exp=0/cafe0002/2", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_rdy;
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_rdy = 4'(1 << exp_order[i]);
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(exp_order[i]) || out_data !== {8{4'(exp_order[i])}}) begin
        failures++; $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d", i, out_valid, out_ch, out_data, exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    in_data = {32'h0, 32'h0, 32'hBEEF0001, 32'h0};
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 4'hF;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_full_ready[%0d] got=%b exp=0000", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF0001) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/beef0001", i, out_valid, out_data);
      end
    end
    @(negedge clk);
    stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'hBEEF0001 || out_ch !== 2'd1) begin
      failures++; $display("FAIL stall_drain got=%b/%h/%0d exp=0/beef0001/1", out_valid, out_data, out_ch);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_noload got=%b exp=0", out_valid); end
    @(negedge clk);
    stall = 1'b0;
    in_data = {32'h0, 32'h0, 32'h5EED0001, 32'h0};
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL unstall_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5EED0001) begin
      failures++; $display("FAIL unstall_load got=%b/%h exp=1/5eed0001", out_valid, out_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b0;
    in_data = {32'h0, 32'h12345678, 32'h0, 32'h0};
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL flush_pre_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b1; stall = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd2) begin
      failures++; $display("FAIL flush_kill got=%b/%h/%0d exp=0/00000000/2", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL flush_ptr_kept got=%b exp=1000", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int rr_exp[4] = '{0, 1, 2, 0};
    logic [2:0] exp_rdy;
    do_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (in_ready3 !== 3'b000) begin failures++; $display("FAIL oor_ready[%0d] got=%b exp=000", i, in_ready3); end
      @(posedge clk); #1;
      checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL oor_valid[%0d] got=%b exp=0", i, out_valid3); end
    end
    @(negedge clk);
    sel3 = 2'd2;
    #1;
    checks++; if (in_ready3 !== 3'b100) begin failures++; $display("FAIL n3_top_ready got=%b exp=100", in_ready3); end
    @(posedge clk); #1;
    checks++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 32'hC2C2C2C2) begin
      failures++; $display("FAIL n3_top_load got=%b/%0d/%h exp=1/2/c2c2c2c2", out_valid3, out_ch3, out_data3);
    end
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mode3 = 1'b1;
      #1;
      exp_rdy = 3'(1 << rr_exp[i]);
      checks++; if (in_ready3 !== exp_rdy) begin failures++; $display("FAIL n3_rr[%0d] got=%b exp=%b", i, in_ready3, exp_rdy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
      failures++; $display("FAIL mid_pre got=%b/%0d exp=1/1", out_valid, out_ch);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_async got=%b/%h/%0d/%b exp=0/0/0/0000", out_valid, out_data, out_ch, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL mid_restart_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'hE0) begin
      failures++; $display("FAIL mid_restart_load got=%b/%0d/%h exp=1/0/e0", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_random();
    int g;
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant();
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      @(posedge clk);
      model_edge(g);
      #1;
      checks++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
        failures++; $display("FAIL rand_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_out_of_range();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
